// File: rtl/keypad_key_buffer.sv
// Captures one 4-bit key event per scanner press and queues it in a FWFT FIFO.
// Optional macro KEYBUF_OVERWRITE_EN: a push into a full FIFO replaces the oldest entry.
module keypad_key_buffer #(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             valid,
  input  logic [3:0]       code,
  input  logic             key_pop,
  input  logic             ovf_clr,
  output logic [3:0]       key_data,
  output logic             key_avail,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ARM, WAIT_REL} state_t;

  state_t           state;
  logic [3:0]       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  logic push;
  logic pop;
  logic do_write;
  logic adv_rd;
  logic drop;

  assign key_avail = (count != '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign key_data  = key_avail ? mem[rd_ptr] : 4'h0;

  always_comb begin
    push     = (state == ARM);
    pop      = key_pop && key_avail;
    do_write = push && (!full || pop);
    adv_rd   = pop;
    drop     = push && full && !pop;
`ifdef KEYBUF_OVERWRITE_EN
    // Full without a pop: replace the oldest entry so the newest keys survive.
    if (drop) begin
      do_write = 1'b1;
      adv_rd   = 1'b1;
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE:     if (valid) state <= ARM;
        ARM:      state <= WAIT_REL;
        WAIT_REL: if (!valid) state <= IDLE;
        default:  state <= IDLE;
      endcase

      if (do_write) wr_ptr <= wr_ptr + PTR_W'(1);
      if (adv_rd)   rd_ptr <= rd_ptr + PTR_W'(1);

      if (do_write && !adv_rd) begin
        count <= count + CNT_W'(1);
      end else if (adv_rd && !do_write) begin
        count <= count - CNT_W'(1);
      end

      // A drop in the same cycle as a clear leaves the flag set.
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  // Storage carries no reset; entries are only visible through count.
  always_ff @(posedge clock) begin
    if (do_write) mem[wr_ptr] <= code;
  end

endmodule

// File: tb/tb_keypad_key_buffer.sv
// Self-checking bench for keypad_key_buffer: vector table plus scoreboard queue of expected keys.
module tb_keypad_key_buffer;

  localparam int DEPTH = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       valid = 1'b0;
  logic [3:0] code = 4'h0;
  logic       key_pop = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [3:0] key_data;
  logic       key_avail;
  logic [3:0] count;
  logic       full;
  logic       overflow;

  keypad_key_buffer #(.DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .valid    (valid),
    .code     (code),
    .key_pop  (key_pop),
    .ovf_clr  (ovf_clr),
    .key_data (key_data),
    .key_avail(key_avail),
    .count    (count),
    .full     (full),
    .overflow (overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] code;
    int         hold;
    int         pops;
  } vec_t;

  vec_t       vecs[6];
  int         compared = 0;
  int         mismatched = 0;
  logic [3:0] q[$];
  logic       exp_ovf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, " count"}, 32'(count), 32'(q.size()));
    chk({tag, " key_avail"}, 32'(key_avail), 32'(q.size() != 0));
    chk({tag, " full"}, 32'(full), 32'(q.size() == DEPTH));
    chk({tag, " overflow"}, 32'(overflow), 32'(exp_ovf));
    chk({tag, " key_data"}, 32'(key_data), (q.size() != 0) ? 32'(q[0]) : 32'h0);
  endtask

  task automatic model_push(input logic [3:0] k);
    if (q.size() < DEPTH) begin
      q.push_back(k);
    end else begin
      exp_ovf = 1'b1;
`ifdef KEYBUF_OVERWRITE_EN
      void'(q.pop_front());
      q.push_back(k);
`endif
    end
  endtask

  // Valid high for 'hold' cycles; code settles one cycle after valid rises.
  task automatic press(input logic [3:0] k, input int hold);
    @(negedge clock);
    valid = 1'b1;
    code  = 4'($urandom);
    for (int i = 1; i <= hold; i++) begin
      @(negedge clock);
      if (i == 1) code = k;
      if (i == hold) valid = 1'b0;
    end
    repeat (2) @(negedge clock);
    model_push(k);
  endtask

  task automatic do_pop();
    chk("pop head", 32'(key_data), (q.size() != 0) ? 32'(q[0]) : 32'h0);
    key_pop = 1'b1;
    @(negedge clock);
    key_pop = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  // One-cycle press whose internal push cycle also carries key_pop and/or ovf_clr.
  task automatic press_pop(input logic [3:0] k, input logic p, input logic clr);
    @(negedge clock);
    valid = 1'b1;
    code  = 4'($urandom);
    @(negedge clock);
    code    = k;
    valid   = 1'b0;
    key_pop = p;
    ovf_clr = clr;
    if (p && q.size() != 0) chk("push+pop head", 32'(key_data), 32'(q[0]));
    @(negedge clock);
    key_pop = 1'b0;
    ovf_clr = 1'b0;
    if (p && q.size() != 0) void'(q.pop_front());
    if (clr) exp_ovf = 1'b0;
    model_push(k);
    @(negedge clock);
  endtask

  initial begin
    vecs[0] = '{code: 4'h3, hold: 5, pops: 0};
    vecs[1] = '{code: 4'h7, hold: 1, pops: 0};
    vecs[2] = '{code: 4'hC, hold: 3, pops: 3};
    vecs[3] = '{code: 4'h1, hold: 2, pops: 0};
    vecs[4] = '{code: 4'hE, hold: 1, pops: 1};
    vecs[5] = '{code: 4'h0, hold: 4, pops: 2};

    repeat (2) @(negedge clock);
    reset = 1'b0;
    check_state("reset");

    // Single press latency: entry appears two edges after valid rises.
    @(negedge clock);
    valid = 1'b1;
    code  = 4'($urandom);
    @(negedge clock);
    chk("latency edge1 count", 32'(count), 32'h0);
    code  = 4'hA;
    valid = 1'b0;
    @(negedge clock);
    chk("latency edge2 count", 32'(count), 32'h1);
    chk("latency edge2 avail", 32'(key_avail), 32'h1);
    chk("latency edge2 data", 32'(key_data), 32'hA);
    q.push_back(4'hA);
    @(negedge clock);
    do_pop();
    check_state("single pop");

    for (int i = 0; i < 6; i++) begin
      press(vecs[i].code, vecs[i].hold);
      check_state($sformatf("vec%0d press", i));
      for (int j = 0; j < vecs[i].pops; j++) do_pop();
      check_state($sformatf("vec%0d pops", i));
    end

    for (int k = 0; k < 8; k++) press(4'(k), 1);
    check_state("fill 0..7");
    press(4'hF, 2);
    check_state("ninth key");
    repeat (8) do_pop();
    check_state("drain after ovf");

    @(negedge clock);
    ovf_clr = 1'b1;
    @(negedge clock);
    ovf_clr = 1'b0;
    exp_ovf = 1'b0;
    check_state("ovf_clr");

    for (int k = 8; k < 16; k++) press(4'(k), 1);
    check_state("refill");
    press_pop(4'h9, 1'b1, 1'b0);
    check_state("full push+pop");
    repeat (8) do_pop();
    check_state("drain2");

    press_pop(4'h5, 1'b1, 1'b0);
    check_state("empty push+pop");
    for (int k = 0; k < 7; k++) press(4'(k + 2), 2);
    check_state("fill3");
    press_pop(4'hD, 1'b0, 1'b1);
    check_state("ovf set vs clr");
    repeat (5) do_pop();
    check_state("count3");

    // Asynchronous reset while the capture FSM is in ARM.
    @(negedge clock);
    valid = 1'b1;
    code  = 4'h2;
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("async rst count", 32'(count), 32'h0);
    chk("async rst avail", 32'(key_avail), 32'h0);
    chk("async rst overflow", 32'(overflow), 32'h0);
    chk("async rst data", 32'(key_data), 32'h0);
    valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    q.delete();
    exp_ovf = 1'b0;
    repeat (3) @(negedge clock);
    check_state("after async rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/keypad_key_buffer.md
Name: keypad_key_buffer

Overview:
- Downstream consumer of the hex keypad scanner's valid and code outputs.
- Turns each key press into exactly one 4-bit key event and queues it in a first-word-fall-through FIFO.
- Host logic (CPU or display controller) drains the FIFO with a pop handshake.
- Decouples key-press timing from consumer timing; reports lost keys with a sticky overflow flag.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count (derived; not overridden).

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- valid  input  1  key-detected strobe from the scanner; high for one or more cycles per press.
- code  input  4  key code from the scanner; registered there, so it is correct in the cycle after valid first rises.
- key_pop  input  1  consumer removes the head entry; ignored when empty.
- ovf_clr  input  1  clears the overflow flag.
- key_data  output  4  head entry of the FIFO (FWFT); 4'h0 when empty.
- key_avail  output  1  high when count != 0.
- count  output  CNT_W  current occupancy, 0..DEPTH.
- full  output  1  high when count == DEPTH.
- overflow  output  1  sticky: set when a key event is dropped.

Behaviour:
- Reset (asynchronous, active-high):
  - FSM goes to IDLE; read/write pointers and count go to 0.
  - key_data=4'h0, key_avail=0, full=0, overflow=0.
  - A capture in progress is discarded. FIFO contents need not be cleared.
- Capture FSM, 3 states:
  - IDLE: valid=1 -> ARM; otherwise stay.
  - ARM: sample code this cycle and issue one push -> WAIT_REL.
  - WAIT_REL: valid=0 -> IDLE; otherwise stay. This blocks duplicate pushes if valid is held for several cycles.
  - Latency: a valid rise at edge N gives a push at edge N+1. The entry is visible on key_data/key_avail after edge N+2 if the FIFO was empty.
- FIFO:
  - FWFT: key_data = mem[rd_ptr] when count != 0, else 4'h0.
  - Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - Push while not full: write at wr_ptr, wr_ptr+1, count+1.
  - Pop while not empty: rd_ptr+1, count-1.
  - Simultaneous push and pop, not empty: both happen, count unchanged.
  - Simultaneous push and pop, full: both happen, count stays DEPTH, no overflow.
  - Simultaneous push and pop, empty: the pop is ignored; the push proceeds and count becomes 1.
  - Push while full without pop: follows the KEYBUF_OVERWRITE_EN rules below; overflow is set in the same edge.
- overflow:
  - Set by a dropped or overwritten event.
  - Cleared by ovf_clr only. If set and clear happen in the same cycle, set wins.
- No combinational path from valid or code to any output; all outputs are registered or decoded from registers.

Optional Feature:
- Macro KEYBUF_OVERWRITE_EN.
- Defined: a push while full without pop overwrites the oldest entry. Write at wr_ptr, advance both wr_ptr and rd_ptr, count stays DEPTH, overflow=1. The FIFO always holds the newest DEPTH keys.
- Not defined: a push while full without pop is discarded. Pointers and count are unchanged, overflow=1. The FIFO holds the oldest DEPTH keys.

Test Plan:
- Reset, then a single press: valid high 1 cycle with code=4'hA the following cycle -> count=1, key_avail=1, key_data=4'hA two edges after the valid rise; key_pop for one cycle -> count=0, key_data=4'h0.
- valid held high for 5 cycles with code=4'h3 -> exactly one entry (count=1). After valid drops, a second press with code=4'h7 -> count=2; entries read out in order 3, then 7.
- Push 8 keys 0..7 into DEPTH=8 -> full=1, count=8. A 9th key 4'hF, macro undefined -> overflow=1 and pops return 0..7. Same sequence with macro defined -> pops return 1..7 then F.
- FIFO full, then key_pop asserted in the same cycle as an internal push -> count stays 8, overflow stays 0, head advances.
- Empty FIFO, key_pop asserted alongside a push of 4'h5 -> count=1, key_data=4'h5. ovf_clr asserted in the same cycle as an overflow event -> overflow stays 1.
- Reset asserted asynchronously while in ARM with count=3 -> immediately count=0, key_avail=0, overflow=0; the in-flight key is not pushed after reset releases.
